spi_regfile: RTL

SPI peripheral with a parameterised register file, for the SPI control path of the user design. It decodes mode-0 frames carrying write/read, address and data, and supports both writes and read-back on CIPO. Register count and data width are parameters, and each register can be written from the controller. Registers drive downstream logic, such as PWM configuration, through a flat output bus with per-register write strobes.

---
 rtl/spi_regfile.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_regfile.sv
// spi_regfile - SPI (mode 0) peripheral exposing a parameterised register file.
//
// A frame is rw (1 = write, 0 = read), then ADDR_W address bits, then DATA_W
// data bits, all MSB first. Writes land in the addressed register and pulse
// its write strobe. Reads shift the addressed register out on CIPO. All
// inputs are asynchronous to clk and are oversampled.
//
// Ports
//   clk        system clock (only clock)
//   rst_n      synchronous active-low reset
//   SCLK       SPI clock, mode 0, asynchronous
//   nCS        chip select, active low, asynchronous
//   COPI       controller-out data, asynchronous
//   CIPO       peripheral-out data (0 whenever CIPO_oe is 0)
//   CIPO_oe    output enable for CIPO
//   regs       flat register bus, register r at [r*DATA_W +: DATA_W]
//   wr_strobe  one-cycle pulse on the bit of the register just written
//   frame_err  one-cycle pulse on an aborted frame or write to a bad address
module spi_regfile #(
  parameter int DATA_W      = 8,
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         SCLK,
  input  logic                         nCS,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic                         CIPO_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int CNT_MAX  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_CYC = SETTLE_W'(SYNC_STAGES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_COMMIT,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizers. Bit 0 is the newest sample; SCLK and nCS carry one
  // extra flop beyond the synchronizer for edge detection.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES:0]   sclk_sync_q;
  logic [SYNC_STAGES:0]   ncs_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      ncs_sync_q  <= '1;
      copi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], SCLK};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-1:0], nCS};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], COPI};
    end
  end

  logic sclk_s, ncs_s, copi_s;
  logic sclk_rise, sclk_fall, ncs_fall, ncs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~sclk_sync_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_s &  sclk_sync_q[SYNC_STAGES];
  assign ncs_fall  = ~ncs_s  &  ncs_sync_q[SYNC_STAGES];
  assign ncs_rise  =  ncs_s  & ~ncs_sync_q[SYNC_STAGES];

  // ---------------------------------------------------------------------------
  // Arming. The synchronizer resets to nCS=1, so the first cycles after reset
  // do not reflect the pin. Only once the whole chain has been refilled from
  // the pin is a high nCS trusted; otherwise a frame already running at reset
  // release would look like a fresh ncs_fall.
  // ---------------------------------------------------------------------------
  logic [SETTLE_W-1:0] settle_q;
  logic                armed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      if (settle_q != SETTLE_CYC) begin
        settle_q <= settle_q + SETTLE_W'(1);
      end
      if ((settle_q == SETTLE_CYC) && ncs_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame state machine and datapath
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W:0]     cmd_q, cmd_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                err_q, err_d;
  logic                wr_en;
  logic [ADDR_W:0]     cmd_shift;
  logic [DATA_W-1:0]   rd_data;
  logic [DATA_W-1:0]   reg_q [NUM_REGS];
  logic [NUM_REGS-1:0] strobe_q;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < (ADDR_W + 1)'(NUM_REGS));
  endfunction

  assign cmd_shift = (cmd_q << 1) | (ADDR_W + 1)'(copi_s);

  // Read mux addressed by the command as it completes on the last address bit.
  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (cmd_shift[ADDR_W-1:0] == ADDR_W'(r)) begin
        rd_data = reg_q[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cmd_q   <= '0;
      data_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    out_d   = out_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ncs_fall && armed_q) begin
          state_d = S_CMD;
          cnt_d   = CNT_W'(ADDR_W);
          cmd_d   = '0;
          out_d   = '0;
        end
      end

      S_CMD: begin
        if (ncs_rise) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          cmd_d = cmd_shift;
          if (cnt_q == '0) begin
            state_d = S_DATA;
            cnt_d   = CNT_W'(DATA_W - 1);
            // Read data is captured here, so the MSB is on CIPO before the
            // first data-phase rising edge.
            if (!cmd_shift[ADDR_W] && addr_ok(cmd_shift[ADDR_W-1:0])) begin
              out_d = rd_data;
            end else begin
              out_d = '0;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_DATA: begin
        if (ncs_rise) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (sclk_rise) begin
          data_d = (data_q << 1) | DATA_W'(copi_s);
          if (cnt_q == '0) begin
            state_d = S_COMMIT;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end else if (sclk_fall && !cmd_q[ADDR_W] &&
                     (cnt_q != CNT_W'(DATA_W - 1))) begin
          // The falling edge between the last address bit and the first data
          // bit must keep the MSB in place; only falls that follow a data-bit
          // rise advance the shift-out register.
          out_d = out_q << 1;
        end
      end

      S_COMMIT: begin
        if (cmd_q[ADDR_W]) begin
          if (addr_ok(cmd_q[ADDR_W-1:0])) begin
            wr_en = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        // A deselect seen during this single cycle must not be lost.
        state_d = ncs_rise ? S_IDLE : S_DONE;
      end

      S_DONE: begin
        if (ncs_rise) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file and write strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      strobe_q <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        reg_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        strobe_q[r] <= wr_en && (cmd_q[ADDR_W-1:0] == ADDR_W'(r));
        if (wr_en && (cmd_q[ADDR_W-1:0] == ADDR_W'(r))) begin
          reg_q[r] <= data_q;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : gen_regs_out
      assign regs[gi*DATA_W +: DATA_W] = reg_q[gi];
    end
  endgenerate

  assign wr_strobe = strobe_q;
  assign frame_err = err_q;

  // ---------------------------------------------------------------------------
  // CIPO drive: only during the data/commit/done part of a read frame while
  // the peripheral is still selected.
  // ---------------------------------------------------------------------------
  assign CIPO_oe = !cmd_q[ADDR_W] && !ncs_s &&
                   ((state_q == S_DATA) || (state_q == S_COMMIT) ||
                    (state_q == S_DONE));
  assign CIPO    = CIPO_oe & out_q[DATA_W-1];

endmodule
